// File: rtl/sequential_carry_select_sub.sv
`default_nettype none
// ============================================================================
// Module      : sequential_carry_select_sub
// Description : Digit-serial carry-select subtractor. Computes
//               c = a - b - bi (mod 2^N), W bits per clock. Each slice
//               evaluates the borrow-in-0 and borrow-in-1 differences in
//               parallel, and the registered borrow from the previous slice
//               picks one. Valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_carry_select_sub #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         bo,
  output logic         ov
);

  localparam int S  = N / W;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  // Reject slice widths that do not tile the datapath exactly.
  generate
    if ((W < 1) || ((N % W) != 0)) begin : g_width_check
      $error("sequential_carry_select_sub: N must be a nonzero multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [N-1:0]   c_r;
  logic           borrow_r;
  logic           bo_r;
  logic           ov_r;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   a_k;
  logic [W-1:0]   b_k;
  logic [W:0]     d0;
  logic [W:0]     d1;
  logic [W-1:0]   diff_sel;
  logic           borrow_sel;
  logic           last;

  // Current slice operands, selected by the slice counter.
  assign a_k  = a_r[cnt*W +: W];
  assign b_k  = b_r[cnt*W +: W];
  assign last = (cnt == CW'(S - 1));

  // Both borrow-in candidates are formed in parallel; bit W is the slice borrow.
  assign d0 = {1'b0, a_k} - {1'b0, b_k};
  assign d1 = {1'b0, a_k} - {1'b0, b_k} - (W+1)'(1);

  // The registered borrow from the previous slice selects the live candidate.
  assign diff_sel   = borrow_r ? d1[W-1:0] : d0[W-1:0];
  assign borrow_sel = borrow_r ? d1[W]     : d0[W];

  // Control FSM and datapath registers; results update only on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      borrow_r <= 1'b0;
      bo_r     <= 1'b0;
      ov_r     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bi;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          c_r[cnt*W +: W] <= diff_sel;
          borrow_r        <= borrow_sel;
          if (last) begin
            bo_r  <= borrow_sel;
            // Signed overflow: operand signs differ and the result sign
            // disagrees with the minuend sign.
            ov_r  <= (a_r[N-1] != b_r[N-1]) && (diff_sel[W-1] != a_r[N-1]);
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c         = c_r;
  assign bo        = bo_r;
  assign ov        = ov_r;

endmodule
`default_nettype wire
